// File: rtl/pmem_arbiter.sv
// Arbitrates the I-cache and D-cache line requests onto one shared physical-memory port.
// The winning cache's command, address and writeback line are held stable until mem_resp.
module pmem_arbiter #(
    parameter int s_offset = 5,
    parameter int s_line   = 256
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_pmem_read,
    input  logic [31:0]       i_pmem_address,
    output logic [s_line-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,

    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [31:0]       d_pmem_address,
    input  logic [s_line-1:0] d_pmem_wdata,
    output logic [s_line-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,

    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_address,
    output logic [s_line-1:0] mem_wdata,
    input  logic [s_line-1:0] mem_rdata,
    input  logic              mem_resp
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_I   = 2'd1,
        GNT_D   = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic [31:0] addr_mask = ~((32'd1 << s_offset) - 32'd1);

    state_t            state;
    state_t            state_next;
    logic              prio;
    logic [31:0]       addr_q;
    logic [s_line-1:0] wdata_q;
    logic              write_q;
    logic              d_req;
    logic              grant_i;
    logic              grant_d;

    // prio=0 lets the I-cache win a tie; the two grants can never fire together
    always_comb begin
        d_req   = d_pmem_read | d_pmem_write;
        grant_i = (state == IDLE) && i_pmem_read && (!d_req || !prio);
        grant_d = (state == IDLE) && d_req && (!i_pmem_read || prio);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (grant_i) begin
                    state_next = GNT_I;
                end else if (grant_d) begin
                    state_next = GNT_D;
                end
            end
            GNT_I, GNT_D: begin
                if (mem_resp) begin
                    state_next = RELEASE;
                end
            end
            RELEASE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            prio    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
        end else begin
            state <= state_next;
            if (grant_i) begin
                prio    <= 1'b1;
                addr_q  <= i_pmem_address & addr_mask;
                write_q <= 1'b0;
            end else if (grant_d) begin
                prio    <= 1'b0;
                addr_q  <= d_pmem_address & addr_mask;
                wdata_q <= d_pmem_wdata;
                write_q <= d_pmem_write;
            end
        end
    end

    // Commands come from the captured holding registers, never from live cache inputs
    assign mem_read     = (state == GNT_I) || ((state == GNT_D) && !write_q);
    assign mem_write    = (state == GNT_D) && write_q;
    assign mem_address  = addr_q;
    assign mem_wdata    = wdata_q;

    assign i_pmem_resp  = (state == GNT_I) && mem_resp;
    assign d_pmem_resp  = (state == GNT_D) && mem_resp;
    assign i_pmem_rdata = mem_rdata;
    assign d_pmem_rdata = mem_rdata;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Self-checking bench for pmem_arbiter: vector table, directed corner sequences,
// and randomized traffic checked against a pending-request/priority model.
module tb_pmem_arbiter;

    logic         clk;
    logic         rst;
    logic         i_pmem_read;
    logic [31:0]  i_pmem_address;
    logic [255:0] i_pmem_rdata;
    logic         i_pmem_resp;
    logic         d_pmem_read;
    logic         d_pmem_write;
    logic [31:0]  d_pmem_address;
    logic [255:0] d_pmem_wdata;
    logic [255:0] d_pmem_rdata;
    logic         d_pmem_resp;
    logic         mem_read;
    logic         mem_write;
    logic [31:0]  mem_address;
    logic [255:0] mem_wdata;
    logic [255:0] mem_rdata;
    logic         mem_resp;

    int total = 0;
    int bad   = 0;

    pmem_arbiter #(.s_offset(5), .s_line(256)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_pmem_read    (i_pmem_read),
        .i_pmem_address (i_pmem_address),
        .i_pmem_rdata   (i_pmem_rdata),
        .i_pmem_resp    (i_pmem_resp),
        .d_pmem_read    (d_pmem_read),
        .d_pmem_write   (d_pmem_write),
        .d_pmem_address (d_pmem_address),
        .d_pmem_wdata   (d_pmem_wdata),
        .d_pmem_rdata   (d_pmem_rdata),
        .d_pmem_resp    (d_pmem_resp),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_resp       (mem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit pre_i;
        bit ir;
        bit dr;
        bit dw;
        bit exp_none;
        bit exp_i;
        bit exp_wr;
    } vec_t;

    task automatic check_output(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic do_reset();
        i_pmem_read    = 1'b0;
        d_pmem_read    = 1'b0;
        d_pmem_write   = 1'b0;
        i_pmem_address = '0;
        d_pmem_address = '0;
        d_pmem_wdata   = '0;
        mem_resp       = 1'b0;
        mem_rdata      = '0;
        rst            = 1'b0;
        #1;
        check_output("rst mem_read", mem_read, 0);
        check_output("rst mem_write", mem_write, 0);
        check_output("rst i_resp", i_pmem_resp, 0);
        check_output("rst d_resp", d_pmem_resp, 0);
        check_output("rst mem_address", mem_address, 0);
        check_output("rst mem_wdata", mem_wdata, 0);
        tick();
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    // Starts in an IDLE cycle and returns in the following IDLE cycle
    task automatic apply_stimulus(input string tag, input bit ir, input bit dr, input bit dw,
                                  input logic [31:0] ia, input logic [31:0] da,
                                  input logic [255:0] wd, input int lat,
                                  input bit exp_none, input bit exp_i, input bit exp_wr);
        logic [255:0] rd;
        logic [31:0]  exp_addr;
        i_pmem_read    = ir;
        d_pmem_read    = dr;
        d_pmem_write   = dw;
        i_pmem_address = ia;
        d_pmem_address = da;
        d_pmem_wdata   = wd;
        mem_resp       = 1'($urandom % 2);
        #1;
        check_output({tag, " idle cmd"}, {mem_read, mem_write}, 0);
        check_output({tag, " idle resp"}, {i_pmem_resp, d_pmem_resp}, 0);
        mem_resp = 1'b0;
        tick();
        if (exp_none) begin
            check_output({tag, " no grant"}, {mem_read, mem_write}, 0);
        end else begin
            exp_addr = (exp_i ? ia : da) & 32'hFFFF_FFE0;
            rd = rand_line();
            for (int k = 1; k <= lat; k++) begin
                mem_resp  = (k == lat);
                mem_rdata = (k == lat) ? rd : rand_line();
                #1;
                check_output($sformatf("%s mem_read c%0d", tag, k), mem_read, !exp_wr);
                check_output($sformatf("%s mem_write c%0d", tag, k), mem_write, exp_wr);
                check_output($sformatf("%s mem_address c%0d", tag, k), mem_address, exp_addr);
                if (!exp_i && exp_wr) begin
                    check_output($sformatf("%s mem_wdata c%0d", tag, k), mem_wdata, wd);
                end
                check_output($sformatf("%s i_resp c%0d", tag, k), i_pmem_resp, exp_i && (k == lat));
                check_output($sformatf("%s d_resp c%0d", tag, k), d_pmem_resp, !exp_i && (k == lat));
                if (k == lat) begin
                    check_output({tag, " rdata"}, exp_i ? i_pmem_rdata : d_pmem_rdata, rd);
                end
                // the granted cache's live inputs wander; the port must not follow
                if (exp_i) begin
                    i_pmem_address = $urandom;
                end else begin
                    d_pmem_address = $urandom;
                    d_pmem_wdata   = rand_line();
                end
                tick();
            end
            mem_resp = 1'($urandom % 2);
            if (exp_i) begin
                i_pmem_read = 1'b0;
            end else begin
                d_pmem_read  = 1'b0;
                d_pmem_write = 1'b0;
            end
            #1;
            check_output({tag, " release cmd"}, {mem_read, mem_write}, 0);
            check_output({tag, " release resp"}, {i_pmem_resp, d_pmem_resp}, 0);
            mem_resp = 1'b0;
            tick();
        end
    endtask

    vec_t         vecs[8];
    bit           pend_i, pend_d, pdr, pdw, prio_m, win_i, none;
    logic [31:0]  ia_m, da_m;
    logic [255:0] wd_m;

    initial begin
        vecs[0] = '{pre_i: 0, ir: 1, dr: 0, dw: 0, exp_none: 0, exp_i: 1, exp_wr: 0};
        vecs[1] = '{pre_i: 0, ir: 0, dr: 1, dw: 0, exp_none: 0, exp_i: 0, exp_wr: 0};
        vecs[2] = '{pre_i: 0, ir: 0, dr: 0, dw: 1, exp_none: 0, exp_i: 0, exp_wr: 1};
        vecs[3] = '{pre_i: 0, ir: 0, dr: 1, dw: 1, exp_none: 0, exp_i: 0, exp_wr: 1};
        vecs[4] = '{pre_i: 0, ir: 1, dr: 1, dw: 0, exp_none: 0, exp_i: 1, exp_wr: 0};
        vecs[5] = '{pre_i: 1, ir: 1, dr: 0, dw: 1, exp_none: 0, exp_i: 0, exp_wr: 1};
        vecs[6] = '{pre_i: 1, ir: 1, dr: 0, dw: 0, exp_none: 0, exp_i: 1, exp_wr: 0};
        vecs[7] = '{pre_i: 0, ir: 0, dr: 0, dw: 0, exp_none: 1, exp_i: 0, exp_wr: 0};

        for (int v = 0; v < 8; v++) begin
            do_reset();
            if (vecs[v].pre_i) begin
                apply_stimulus($sformatf("vec%0d pre", v), 1, 0, 0, $urandom, $urandom,
                               rand_line(), 1, 0, 1, 0);
            end
            apply_stimulus($sformatf("vec%0d", v), vecs[v].ir, vecs[v].dr, vecs[v].dw,
                           $urandom, $urandom, rand_line(), $urandom_range(1, 3),
                           vecs[v].exp_none, vecs[v].exp_i, vecs[v].exp_wr);
        end

        do_reset();
        apply_stimulus("iread", 1, 0, 0, 32'h0000_1234, 32'h0, '0, 4, 0, 1, 0);

        do_reset();
        apply_stimulus("sim_i", 1, 0, 1, 32'h100, 32'h200, '1, 2, 0, 1, 0);
        apply_stimulus("sim_d", 0, 0, 1, 32'h100, 32'h200, '1, 3, 0, 0, 1);

        do_reset();
        for (int n = 0; n < 4; n++) begin
            apply_stimulus($sformatf("alt%0d", n), 1, 1, 0, $urandom, $urandom, rand_line(),
                           2, 0, (n % 2) == 0, 0);
        end

        do_reset();
        d_pmem_write   = 1'b1;
        d_pmem_address = 32'h300;
        d_pmem_wdata   = '1;
        tick();
        check_output("areset pre mem_write", mem_write, 1);
        tick();
        tick();
        mem_resp = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        check_output("areset mem_write", mem_write, 0);
        check_output("areset mem_read", mem_read, 0);
        check_output("areset d_resp", d_pmem_resp, 0);
        d_pmem_write = 1'b0;
        mem_resp     = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tick();
        apply_stimulus("areset post", 1, 1, 0, $urandom, $urandom, rand_line(), 2, 0, 1, 0);

        do_reset();
        pend_i = 0;
        pend_d = 0;
        prio_m = 0;
        pdr    = 0;
        pdw    = 0;
        ia_m   = '0;
        da_m   = '0;
        wd_m   = '0;
        for (int it = 0; it < 60; it++) begin
            if (!pend_i && ($urandom % 2 == 1)) begin
                pend_i = 1;
                ia_m   = $urandom;
            end
            if (!pend_d && ($urandom % 2 == 1)) begin
                pend_d = 1;
                case ($urandom % 3)
                    0:       begin pdr = 1; pdw = 0; end
                    1:       begin pdr = 0; pdw = 1; end
                    default: begin pdr = 1; pdw = 1; end
                endcase
                da_m = $urandom;
                wd_m = rand_line();
            end
            none  = !pend_i && !pend_d;
            win_i = (pend_i && pend_d) ? !prio_m : pend_i;
            apply_stimulus($sformatf("rnd%0d", it), pend_i, pend_d && pdr, pend_d && pdw,
                           ia_m, da_m, wd_m, $urandom_range(1, 4), none, win_i,
                           !win_i && pdw);
            if (!none) begin
                prio_m = win_i;
                if (win_i) pend_i = 0;
                else       pend_d = 0;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pmem_arbiter.md
# pmem_arbiter

Two-port physical-memory arbiter between the instruction cache and the data cache of the pipelined core. Each cache presents a 256-bit line request, read for I-cache and read or write for D-cache, with the same handshake it would use toward physical memory. The arbiter grants one cache at a time, latches its address and write line, and drives the single shared memory port. It returns the one-cycle response to the granted cache only.

## Interface
- `s_offset`, 5: byte-offset bits per line; `mem_address[s_offset-1:0]` is forced to 0.
- `s_line`, 256: line width in bits.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low (asserted at 0).
- `i_pmem_read`  in  1  I-cache line-read request; held until `i_pmem_resp`.
- `i_pmem_address`  in  32  I-cache line address.
- `i_pmem_rdata`  out  s_line  line returned to the I-cache.
- `i_pmem_resp`  out  1  one-cycle completion pulse to the I-cache.
- `d_pmem_read`  in  1  D-cache line-read request.
- `d_pmem_write`  in  1  D-cache line-writeback request.
- `d_pmem_address`  in  32  D-cache line address.
- `d_pmem_wdata`  in  s_line  D-cache writeback line.
- `d_pmem_rdata`  out  s_line  line returned to the D-cache.
- `d_pmem_resp`  out  1  one-cycle completion pulse to the D-cache.
- `mem_read`, `mem_write`  out  1  shared-port commands; mutually exclusive.
- `mem_address`  out  32  latched line address.
- `mem_wdata`  out  s_line  latched writeback line.
- `mem_rdata`  in  s_line  shared-port read line.
- `mem_resp`  in  1  shared-port one-cycle completion.

## Operation
- FSM states:
  - IDLE: no grant.
  - GNT_I: I-cache owns the port.
  - GNT_D: D-cache owns the port.
  - RELEASE: one-cycle gap, no grant.
- `prio` bit selects the winner when both caches request in IDLE. Reset value 0 means the I-cache wins.
- IDLE, arbitration on the sampled requests:
  - I-cache only requests: go to GNT_I.
  - D-cache only requests: go to GNT_D.
  - Both request: `prio`=0 goes to GNT_I, `prio`=1 goes to GNT_D.
  - On any grant, `prio` is set to favour the other cache next time.
- On a grant edge, capture the following into holding registers:
  - address, with `[s_offset-1:0]` zeroed;
  - D-cache wdata;
  - command: I-cache always read; D-cache write if `d_pmem_write`, else read. `d_pmem_write` dominates if both are asserted.
- GNT_x:
  - `mem_read`/`mem_write` driven from the captured command, not from live cache inputs.
  - Remains in GNT_x until `mem_resp`=1.
- On `mem_resp` in GNT_x:
  - `x_pmem_resp`=1 in the same cycle, combinational.
  - `x_pmem_rdata` = `mem_rdata`.
  - Next state RELEASE.
- RELEASE:
  - All commands and responses are 0.
  - Requests are ignored, which gives the cache one cycle to drop its request.
  - Next state IDLE.
- The non-granted cache always sees resp=0. Its request stays pending and wins at the next IDLE if it is still asserted.
- `i_pmem_rdata` and `d_pmem_rdata` may both mirror `mem_rdata` at all times; only the resp pulses qualify the data.
- A `mem_resp` arriving in IDLE or RELEASE is ignored and produces no cache resp.

## Timing
- Reset, asynchronous:
  - State goes to IDLE and `prio` to 0.
  - Holding registers clear to 0.
  - `mem_read`, `mem_write`, `i_pmem_resp`, `d_pmem_resp` are 0 immediately.
  - `mem_address` and `mem_wdata` are 0.
- Reset mid-transaction abandons the transaction; no resp is issued. Memory is assumed reset on the same `rst`.
- Latency:
  - Request sampled in IDLE at edge N.
  - `mem_read` or `mem_write` high from cycle N+1.
  - Cache resp in the same cycle as `mem_resp`.
- Minimum spacing between two grants is `mem_resp` cycle + RELEASE + IDLE arbitration, i.e. the next command rises 3 cycles after the previous `mem_resp` cycle.
- Commands stay asserted and stable, with address and wdata constant, for the whole GNT_x interval.
- A request that drops before `mem_resp` does not cancel the transaction; the arbiter completes it and pulses resp.

## Test plan
- I-cache read alone:
  - Stimulus: `i_pmem_read`=1, address 0x0000_1234; memory responds 4 cycles after `mem_read`.
  - Required: `mem_address`=0x0000_1220; `mem_read` high 4 cycles; `i_pmem_resp` pulses once with `mem_rdata`; `d_pmem_resp` stays 0.
- Simultaneous requests after reset:
  - Stimulus: I read 0x100 and D write 0x200 (wdata all-ones) assert in the same cycle.
  - Required: I-cache is served first; D write follows, with `mem_write` on the cycle 3 after the I resp cycle and `mem_wdata`=all-ones.
- Priority alternation:
  - Stimulus: both caches request continuously for 4 transactions.
  - Required: grant order I, D, I, D; no cache gets two consecutive grants while the other waits.
- D read/write conflict:
  - Stimulus: `d_pmem_read` and `d_pmem_write` asserted together.
  - Required: only `mem_write` is asserted.
- Stable capture:
  - Stimulus: D-cache changes `d_pmem_address`/`d_pmem_wdata` mid-GNT_D.
  - Required: `mem_address`/`mem_wdata` are unchanged until `mem_resp`.
- Asynchronous reset in GNT_D:
  - Stimulus: `rst`=0 two cycles into GNT_D.
  - Required: `mem_write` drops without waiting for `clk`; no `d_pmem_resp`; after release, the first simultaneous request again goes to the I-cache.
